multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL provide clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL provide reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL provide imem_ready, input, 1 bit: instruction memory holds valid data on instruction this cycle.
REQ-004 SHALL provide instruction, input, 32 bits: fetched RV32I word, sampled only when imem_req and imem_ready are both 1.
REQ-005 SHALL provide imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 SHALL provide ir_write, output, 1 bit: one-cycle pulse marking the cycle the instruction is captured.
REQ-007 SHALL provide pc_write, output, 1 bit: one-cycle pulse enabling the pc register to load pc_plus_4.
REQ-008 SHALL provide reg_write, output, 1 bit: register_file write_enable.
REQ-009 SHALL provide rs1, rs2, rd, outputs, 5 bits each: register_file addresses decoded from the latched instruction.
REQ-010 SHALL provide alu_op, output, 3 bits: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7.
REQ-011 SHALL provide use_imm, output, 1 bit: ALU b input selects the sign_extend output.
REQ-012 SHALL provide illegal, output, 1 bit: sticky flag for an undecodable instruction.
REQ-013 SHALL provide state, output, 3 bits: current FSM state code.
REQ-014 SHALL provide retired_count, output, 32 bits: count of completed instructions.

Function
REQ-015 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, TRAP=4; codes 5-7 SHALL go to FETCH on the next cycle.
REQ-016 FETCH: imem_req=1; with imem_ready=1, SHALL latch instruction into an internal IR, pulse ir_write, and go to DECODE; with imem_ready=0, SHALL stay in FETCH without limit.
REQ-017 imem_ready in any state other than FETCH SHALL be ignored.
REQ-018 DECODE: opcode 0110011 (R-type) or 0010011 (I-type) with a legal funct combination SHALL go to EXECUTE; any other opcode or combination SHALL go to TRAP and set illegal the next cycle.
REQ-019 R-type decode SHALL map as follows; all other funct3/funct7 pairs are illegal.
- f3=000 with f7=0000000 -> ADD; f3=000 with f7=0100000 -> SUB.
- With f7=0000000: f3=111 -> AND, 110 -> OR, 100 -> XOR, 001 -> SLL, 101 -> SRL, 010 -> SLT.
REQ-020 I-type decode SHALL map as follows; use_imm=1 for every I-type instruction.
- f3=000 -> ADD, 111 -> AND, 110 -> OR, 100 -> XOR, 010 -> SLT.
- f3=001 -> SLL and f3=101 -> SRL, legal only when imm[11:5]=0.
- f3=011 is illegal.
REQ-021 rs1, rs2, rd, alu_op and use_imm SHALL be registered in DECODE and held stable through EXECUTE and WRITEBACK.
REQ-022 EXECUTE SHALL last exactly one cycle and then go to WRITEBACK.
REQ-023 WRITEBACK SHALL pulse pc_write, assert reg_write only if rd!=0, increment retired_count modulo 2^32 (0xFFFFFFFF wraps to 0), and go to FETCH.
REQ-024 With imem_ready held at 1, each instruction SHALL take exactly 4 cycles.
REQ-025 TRAP SHALL hold with illegal=1 and imem_req, ir_write, pc_write and reg_write all 0 until reset.
REQ-026 reg_write and pc_write SHALL never be 1 outside WRITEBACK, and ir_write SHALL never be 1 outside FETCH.

Reset
REQ-027 While reset=1 at a clock edge, the next state SHALL be FETCH from any state, including mid-instruction and TRAP.
REQ-028 Reset SHALL clear all outputs and the IR to 0, and clear illegal and retired_count to 0.
REQ-029 In the first cycle after reset deasserts, the block SHALL be in FETCH with imem_req=1.

Verification
REQ-030 Reset, then 0x005303b3 (add x7,x6,x5) with imem_ready=1 -> ir_write in cycle 0, rs1=6, rs2=5, rd=7, alu_op=0, use_imm=0, reg_write and pc_write in cycle 3, retired_count=1.
REQ-031 0x40848533 (sub) followed by 0x00160693 (addi x13,x12,1) -> alu_op=1 then alu_op=0 with use_imm=1, rd=13, retired_count=2 after 8 cycles.
REQ-032 imem_ready=0 for 5 cycles, then 1 -> FETCH holds 5 cycles, ir_write only on the ready cycle, no pc_write during the stall.
REQ-033 Instruction 0x00000000 -> TRAP after DECODE, illegal=1, no reg_write or pc_write for 10 further cycles; reset -> FETCH and illegal=0.
REQ-034 add with rd=x0 -> pc_write=1 and reg_write=0 in WRITEBACK; reset asserted in EXECUTE of the next instruction -> no writes, FETCH next cycle, retired_count=0.
REQ-035 Preload retired_count to 0xFFFFFFFF via 2^32-1 forced or backdoor retirements, then retire one instruction -> retired_count=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: FETCH -> DECODE -> EXECUTE -> WRITEBACK, with a
// sticky TRAP on undecodable instructions and a retired-instruction counter.
module multicycle_control #(
  parameter logic [31:0] RETIRED_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic [31:0] instruction,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  alu_op,
  output logic        use_imm,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_TRAP      = 3'd4
  } state_e;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [4:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        use_imm_q, use_imm_d;
  logic        illegal_q, illegal_d;
  logic [31:0] retired_q, retired_d;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        dec_legal;
  logic [2:0]  dec_op;
  logic        dec_imm;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  // Shared funct3 -> ALU operation map for both R-type (funct7=0) and I-type.
  function automatic logic [2:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_op = OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = OP_SRL;
      3'b110:  f3_op = OP_OR;
      3'b111:  f3_op = OP_AND;
      default: f3_op = OP_ADD;
    endcase
  endfunction

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_imm   = 1'b0;
    case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000000) begin
          dec_legal = (funct3 != 3'b011);
          dec_op    = f3_op(funct3);
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OP_SUB;
        end
      end
      OPC_I: begin
        dec_imm = 1'b1;
        dec_op  = f3_op(funct3);
        case (funct3)
          3'b011:         dec_legal = 1'b0;
          3'b001, 3'b101: dec_legal = (funct7 == 7'b0000000);
          default:        dec_legal = 1'b1;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    alu_op_d  = alu_op_q;
    use_imm_d = use_imm_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          ir_d     = instruction;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          rs1_d     = ir_q[19:15];
          rs2_d     = ir_q[24:20];
          rd_d      = ir_q[11:7];
          alu_op_d  = dec_op;
          use_imm_d = dec_imm;
          state_d   = S_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXECUTE: state_d = S_WRITEBACK;
      S_WRITEBACK: begin
        pc_write  = 1'b1;
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Strobes are silenced during reset so nothing leaks out of a reset cycle.
    if (reset) begin
      imem_req = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      alu_op_q  <= '0;
      use_imm_q <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= RETIRED_INIT;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      alu_op_q  <= alu_op_d;
      use_imm_q <= use_imm_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign reg_write     = pc_write && (rd_q != 5'd0);
  assign rs1           = rs1_q;
  assign rs2           = rs2_q;
  assign rd            = rd_q;
  assign alu_op        = alu_op_q;
  assign use_imm       = use_imm_q;
  assign illegal       = illegal_q;
  assign state         = state_q;
  assign retired_count = retired_q;

endmodule
